// File: rtl/com_arb_pkg.sv
// com_arb_pkg: shared types and constants for the ComSender arbiter.
//   state_t  : transaction FSM states
//   CMD_W    : command width sent to ComSender
//   RESP_W   : response byte width received from ComSender
//   ERR_RESP : response value reported when the watchdog expires
package com_arb_pkg;

  localparam int CMD_W  = 16;
  localparam int RESP_W = 8;
  localparam logic [RESP_W-1:0] ERR_RESP = 8'hFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_SENT = 3'd2,
    WAIT_RESP = 3'd3,
    DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req     : request vector
//   pointer : index where the search starts (wraps modulo NUM_REQ)
//   grant   : one-hot winner (all zero when no request)
//   index   : binary index of the winner
//   valid   : at least one request present
module rr_arbiter
  import com_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               valid
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  // Scan requesters starting at pointer; the first one found wins.
  always_comb begin
    grant = {NUM_REQ{1'b0}};
    index = {IDX_W{1'b0}};
    valid = 1'b0;
    cand  = {CW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, pointer} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid                   = 1'b1;
        index                   = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]  = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/com_arbiter.sv
// com_arbiter: shares one ComSender link among NUM_REQ requesters.
// One transaction = grant, send command, wait for cmd_sent, wait for a
// response byte, pulse done to the owner. Round-robin fairness.
// Ports:
//   clk, rst            : clock, async active-high reset
//   req, req_cmd        : per-requester request level and 16-bit command
//   gnt, done           : one-hot grant (whole transaction), done pulse
//   rsp_data, rsp_err   : captured response byte, timeout flag
//   cmd, send_cmd       : command and start pulse to ComSender
//   cmd_sent            : ComSender finished transmitting
//   resp, resp_rdy      : ComSender received byte and its valid flag
//   clr_resp_rdy        : one-cycle clear of resp_rdy
// Optional feature: define COM_ARB_TIMEOUT_EN to enable the response
// watchdog (TIMEOUT_CYCLES); without it the WAIT states never time out.
module com_arbiter
  import com_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [CMD_W*NUM_REQ-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [RESP_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [CMD_W-1:0]          cmd,
  output logic                      send_cmd,
  input  logic                      cmd_sent,
  input  logic [RESP_W-1:0]         resp,
  input  logic                      resp_rdy,
  output logic                      clr_resp_rdy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("com_arbiter: unsupported parameter value");
  end

  state_t              state;
  state_t              next_state;
  logic [IDX_W-1:0]    idx;        // owner of the current transaction
  logic [IDX_W-1:0]    rr_start;   // first index searched on the next grant
  logic [IDX_W-1:0]    arb_idx;
  logic [NUM_REQ-1:0]  arb_grant;
  logic                arb_valid;
  logic [CMD_W-1:0]    sel_cmd;
  logic                capture;
  logic                timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req),
    .pointer (rr_start),
    .grant   (arb_grant),
    .index   (arb_idx),
    .valid   (arb_valid)
  );

  // Pick the command slice belonging to the arbitration winner.
  always_comb begin
    sel_cmd = {CMD_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_cmd = req_cmd[i*CMD_W +: CMD_W];
      end else begin
        sel_cmd = sel_cmd;
      end
    end
  end

  assign capture = (state == WAIT_RESP) && resp_rdy;

`ifdef COM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_flag;

  // Fires on the TIMEOUT_CYCLES-th cycle spent in the WAIT states.
  assign timeout = ((state == WAIT_SENT) || (state == WAIT_RESP)) &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: cleared while in ISSUE, counts in WAIT states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= {CNT_W{1'b0}};
    end else if (state == ISSUE) begin
      wait_cnt <= {CNT_W{1'b0}};
    end else if ((state == WAIT_SENT) || (state == WAIT_RESP)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Error flag: set by a watchdog expiry, cleared by a real response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= 1'b0;
    end else if (capture) begin
      err_flag <= 1'b0;
    end else if (timeout) begin
      err_flag <= 1'b1;
    end else begin
      err_flag <= err_flag;
    end
  end

  assign rsp_err = err_flag;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Next-state logic of the transaction FSM.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (arb_valid) next_state = ISSUE;
        else           next_state = IDLE;
      end
      ISSUE: next_state = WAIT_SENT;
      WAIT_SENT: begin
        if (cmd_sent)     next_state = WAIT_RESP;
        else if (timeout) next_state = DONE;
        else              next_state = WAIT_SENT;
      end
      WAIT_RESP: begin
        if (resp_rdy)     next_state = DONE;
        else if (timeout) next_state = DONE;
        else              next_state = WAIT_RESP;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register and registered outputs, decoded from next_state so
  // each output lines up with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= {IDX_W{1'b0}};
      rr_start     <= {IDX_W{1'b0}};
      cmd          <= {CMD_W{1'b0}};
      rsp_data     <= {RESP_W{1'b0}};
      gnt          <= {NUM_REQ{1'b0}};
      done         <= {NUM_REQ{1'b0}};
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
    end else begin
      state    <= next_state;
      send_cmd <= (next_state == ISSUE);
      done     <= (next_state == DONE) ? gnt : {NUM_REQ{1'b0}};
      // An unsolicited byte in IDLE is cleared once; the guard stops a
      // second pulse while ComSender is still dropping resp_rdy.
      clr_resp_rdy <= capture || timeout ||
                      ((state == IDLE) && resp_rdy && !clr_resp_rdy);

      if (next_state == IDLE)  gnt <= {NUM_REQ{1'b0}};
      else if (state == IDLE)  gnt <= arb_grant;
      else                     gnt <= gnt;

      if ((state == IDLE) && arb_valid) begin
        idx <= arb_idx;
        cmd <= sel_cmd;
      end

      if (capture)      rsp_data <= resp;
      else if (timeout) rsp_data <= ERR_RESP;

      // Next search starts just after the requester that was served.
      if (state == DONE) begin
        rr_start <= (idx == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_com_arbiter.sv
module tb_com_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_cmd;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;

  int total = 0;
  int bad   = 0;

  // ComSender model controls
  int          m_delay;
  int          m_cnt;
  logic        m_busy;
  logic        m_resp_en;
  logic [7:0]  m_resp_val;
  logic        m_inject;
  logic [7:0]  m_inj_val;

  logic [15:0] exp_cmd [4];

  always #5 clk = ~clk;

  com_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_cmd      (req_cmd),
    .gnt          (gnt),
    .done         (done),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .cmd          (cmd),
    .send_cmd     (send_cmd),
    .cmd_sent     (cmd_sent),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy)
  );

  // ComSender model: cmd_sent m_delay edges after send_cmd, optional response.
  always @(posedge clk) begin
    if (rst) begin
      cmd_sent <= 1'b0;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
      m_busy   <= 1'b0;
      m_cnt    <= 0;
    end else begin
      if (clr_resp_rdy) resp_rdy <= 1'b0;
      if (send_cmd) begin
        cmd_sent <= 1'b0;
        m_busy   <= 1'b1;
        m_cnt    <= m_delay;
      end else if (m_busy) begin
        if (m_cnt > 1) begin
          m_cnt <= m_cnt - 1;
        end else begin
          m_busy   <= 1'b0;
          cmd_sent <= 1'b1;
          if (m_resp_en) begin
            resp     <= m_resp_val;
            resp_rdy <= 1'b1;
          end
        end
      end
      if (m_inject) begin
        resp     <= m_inj_val;
        resp_rdy <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a send_cmd pulse; counts negedges and done pulses seen.
  task automatic wait_send(output int n, output int dones);
    n = 0;
    dones = 0;
    do begin
      @(negedge clk);
      n++;
      if (done != 4'b0000) dones++;
    end while (!send_cmd && n < 200);
    chk("send_seen", 32'(send_cmd), 32'h1);
  endtask

  // Wait for a done pulse; counts negedges.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 4'b0000 && n < 300);
    chk("done_seen", 32'(|done), 32'h1);
  endtask

  initial begin
    int n;
    int d;
    int clr_n;
    logic [3:0] e;

    exp_cmd[0] = 16'h1234;
    exp_cmd[1] = 16'hA5C3;
    exp_cmd[2] = 16'hC0DE;
    exp_cmd[3] = 16'hD00D;
    rst        = 1'b1;
    req        = 4'b0000;
    req_cmd    = {16'hD00D, 16'hC0DE, 16'hA5C3, 16'h1234};
    m_delay    = 20;
    m_resp_en  = 1'b1;
    m_resp_val = 8'h5A;
    m_inject   = 1'b0;
    m_inj_val  = 8'h33;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt",  32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_send", 32'(send_cmd), 32'h0);
    chk("rst_clr",  32'(clr_resp_rdy), 32'h0);
    chk("rst_err",  32'(rsp_err), 32'h0);
    chk("rst_data", 32'(rsp_data), 32'h0);
    chk("rst_cmd",  32'(cmd), 32'h0);

    // single transaction from requester 1
    rst = 1'b0;
    req = 4'b0010;
    @(negedge clk);
    chk("t1_send", 32'(send_cmd), 32'h1);
    chk("t1_cmd",  32'(cmd), 32'hA5C3);
    chk("t1_gnt",  32'(gnt), 32'h2);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_send_once", 32'(send_cmd), 32'h0);
    chk("t1_gnt_hold",  32'(gnt), 32'h2);
    n = 0;
    clr_n = 0;
    do begin
      @(negedge clk);
      n++;
      clr_n += int'(clr_resp_rdy);
    end while (done == 4'b0000 && n < 100);
    chk("t1_latency", 32'(n), 32'd22);
    chk("t1_done",    32'(done), 32'h2);
    chk("t1_data",    32'(rsp_data), 32'h5A);
    chk("t1_err",     32'(rsp_err), 32'h0);
    @(negedge clk);
    clr_n += int'(clr_resp_rdy);
    chk("t1_done_once", 32'(done), 32'h0);
    chk("t1_gnt_idle",  32'(gnt), 32'h0);
    chk("t1_clr_count", 32'(clr_n), 32'h1);
    chk("t1_cmd_hold",  32'(cmd), 32'hA5C3);

    // unsolicited byte in IDLE
    m_inject = 1'b1;
    @(negedge clk);
    m_inject = 1'b0;
    chk("us_clr0", 32'(clr_resp_rdy), 32'h0);
    @(negedge clk);
    chk("us_clr1", 32'(clr_resp_rdy), 32'h1);
    chk("us_data", 32'(rsp_data), 32'h5A);
    chk("us_done", 32'(done), 32'h0);
    @(negedge clk);
    chk("us_clr2", 32'(clr_resp_rdy), 32'h0);
    chk("us_done2", 32'(done), 32'h0);
    chk("us_gnt", 32'(gnt), 32'h0);

    // requester 2 drops req during WAIT_SENT
    m_delay    = 5;
    m_resp_val = 8'h77;
    req        = 4'b0100;
    wait_send(n, d);
    chk("drop_gnt", 32'(gnt), 32'h4);
    chk("drop_cmd", 32'(cmd), 32'hC0DE);
    @(negedge clk);
    req = 4'b0000;
    wait_done(n);
    chk("drop_done", 32'(done), 32'h4);
    chk("drop_data", 32'(rsp_data), 32'h77);
    @(negedge clk);
    chk("drop_done_once", 32'(done), 32'h0);

    // reset during WAIT_RESP
    m_delay   = 4;
    m_resp_en = 1'b0;
    req       = 4'b1000;
    wait_send(n, d);
    chk("ab_gnt", 32'(gnt), 32'h8);
    chk("ab_cmd", 32'(cmd), 32'hD00D);
    req = 4'b0000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_sent && n < 50);
    chk("ab_sent_seen", 32'(cmd_sent), 32'h1);
    @(negedge clk);
    chk("ab_gnt_wait", 32'(gnt), 32'h8);
    rst = 1'b1;
    #1;
    chk("ab_gnt0",  32'(gnt), 32'h0);
    chk("ab_done0", 32'(done), 32'h0);
    chk("ab_send0", 32'(send_cmd), 32'h0);
    chk("ab_clr0",  32'(clr_resp_rdy), 32'h0);
    chk("ab_err0",  32'(rsp_err), 32'h0);
    chk("ab_data0", 32'(rsp_data), 32'h0);
    chk("ab_cmd0",  32'(cmd), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    d = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != 4'b0000) d++;
    end
    chk("ab_no_done", 32'(d), 32'h0);

    // all requesters held: rotation starts at 0 after reset
    m_delay    = 3;
    m_resp_en  = 1'b1;
    m_resp_val = 8'h5A;
    req        = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      e = 4'(4'b0001 << (t % 4));
      wait_send(n, d);
      chk("rr_gnt", 32'(gnt), 32'(e));
      chk("rr_cmd", 32'(cmd), 32'(exp_cmd[t % 4]));
      chk("rr_extra_done", 32'(d), 32'h0);
      wait_done(n);
      chk("rr_done", 32'(done), 32'(e));
    end
    req = 4'b0000;
    @(negedge clk);
    chk("rr_done_once", 32'(done), 32'h0);

`ifdef COM_ARB_TIMEOUT_EN
    // no response: watchdog expires after 100 cycles in WAIT states
    m_delay   = 1000;
    m_resp_en = 1'b0;
    req       = 4'b0010;
    wait_send(n, d);
    chk("to_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    wait_done(n);
    chk("to_latency", 32'(n), 32'd101);
    chk("to_done",    32'(done), 32'h2);
    chk("to_data",    32'(rsp_data), 32'hFF);
    chk("to_err",     32'(rsp_err), 32'h1);
    chk("to_clr",     32'(clr_resp_rdy), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/com_arbiter.md
COM_ARBITER -- requirements
Module: com_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one ComSender link (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: response watchdog limit in clk cycles.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester transaction request, level.
REQ-006 req_cmd  input  16*NUM_REQ  per-requester command; requester i occupies bits [16i+15:16i].
REQ-007 gnt  output  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-008 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 rsp_data  output  8  captured response, shared, valid from done pulse until next capture.
REQ-010 rsp_err  output  1  timeout flag, qualified by done.
REQ-011 cmd  output  16  command to ComSender.
REQ-012 send_cmd  output  1  one-cycle start pulse to ComSender.
REQ-013 cmd_sent  input  1  ComSender status: both bytes transmitted.
REQ-014 resp  input  8  ComSender received byte.
REQ-015 resp_rdy  input  1  ComSender received-byte valid.
REQ-016 clr_resp_rdy  output  1  one-cycle clear of resp_rdy.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_SENT, WAIT_RESP, DONE.
REQ-018 IDLE: any req high -> round-robin selection starting at index after last granted (index 0 after reset); latch index and its req_cmd; next state ISSUE.
REQ-019 req is sampled only in IDLE; req changes during a transaction are ignored and the transaction completes.
REQ-020 gnt[idx] is 1 in ISSUE, WAIT_SENT, WAIT_RESP and DONE; all-zero in IDLE.
REQ-021 ISSUE: send_cmd=1 for exactly one cycle; cmd = latched command; next WAIT_SENT. Latency: req sampled in IDLE cycle N -> send_cmd in N+1.
REQ-022 cmd holds the latched value from ISSUE until next grant.
REQ-023 WAIT_SENT: cmd_sent=1 -> WAIT_RESP (cmd_sent is already cleared by ComSender on the send_cmd edge, so a stale high is never seen here).
REQ-024 WAIT_RESP: resp_rdy=1 -> rsp_data<=resp, rsp_err<=0, clr_resp_rdy=1 same cycle, next DONE.
REQ-025 DONE: done[idx]=1 one cycle; round-robin pointer <= idx; next IDLE.
REQ-026 IDLE with resp_rdy=1 (unsolicited byte): clr_resp_rdy=1 for one cycle, byte discarded, rsp_data unchanged; arbitration proceeds in parallel.
REQ-027 Single requester held high continuously: re-granted on every IDLE pass, minimum 1 IDLE cycle between transactions.
REQ-028 All requesters high: grants rotate 0,1,2,...,NUM_REQ-1,0 with no starvation.

Reset
REQ-029 rst asserted: state IDLE; gnt, done, send_cmd, clr_resp_rdy, rsp_err = 0; rsp_data = 8'h00; cmd = 16'h0000; pointer = 0; timeout counter = 0.
REQ-030 rst mid-transaction aborts it with no done pulse; requester must re-request.

Configuration
REQ-031 Macro COM_ARB_TIMEOUT_EN defined: counter runs in WAIT_SENT/WAIT_RESP, cleared on entry to WAIT_SENT; reaching TIMEOUT_CYCLES -> rsp_data<=8'hFF, rsp_err<=1, clr_resp_rdy=1, next DONE.
REQ-032 Macro undefined: no counter instantiated, WAIT states wait indefinitely, rsp_err tied 0.

Structure
REQ-033 Package com_arb_pkg: state enum, CMD_W=16, RESP_W=8, ERR_RESP=8'hFF.
REQ-034 Sub-module rr_arbiter (req, pointer -> one-hot grant, index) instantiated once.

Verification
REQ-035 req=4'b0010, req_cmd[1]=16'hA5C3; ComSender model cmd_sent after 20 cycles, resp=8'h5A -> send_cmd one cycle with cmd=16'hA5C3, done[1] pulse, rsp_data=8'h5A, rsp_err=0, clr_resp_rdy one pulse.
REQ-036 req=4'b1111 held -> gnt order 0001,0010,0100,1000,0001; exactly one done per grant.
REQ-037 COM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, no resp -> done after 100 cycles in WAIT states, rsp_data=8'hFF, rsp_err=1.
REQ-038 resp_rdy pulsed high in IDLE with resp=8'h33 -> clr_resp_rdy next cycle, rsp_data unchanged, no done.
REQ-039 rst asserted in WAIT_RESP -> all outputs at reset values same cycle, no done; next req granted from index 0.
REQ-040 req[2] dropped in WAIT_SENT -> transaction completes, done[2] pulses.
